// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the convolution post-processing path.
package conv_pkg;

  localparam int DEF_IMG_W = 26;
  localparam int DEF_IMG_H = 26;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 12;

  // Helpers work on a wide container so any IN_W/OUT_W up to 64 bits fits.
  localparam int MAX_W = 64;

  // ReLU, arithmetic right shift, then clamp to the largest positive out_w-bit value.
  function automatic logic [MAX_W-1:0] relu_requant(input logic signed [MAX_W-1:0] d,
                                                    input int shift,
                                                    input int out_w);
    logic signed [MAX_W-1:0] q;
    logic [MAX_W-1:0] sat;
    sat = (64'd1 << (out_w - 1)) - 64'd1;
    if (d < 0) begin
      return '0;
    end
    q = d >>> shift;
    if ($unsigned(q) > sat) begin
      return sat;
    end
    return $unsigned(q);
  endfunction

  // Unsigned maximum; quantized values are never negative.
  function automatic logic [MAX_W-1:0] umax(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the horizontal maxima of the even row of each pooling band.
module pool_line_buffer #(
  parameter int DEPTH = 13,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  logic [DW-1:0] mem [DEPTH];

  // Synchronous write of the even-row horizontal max.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/relu_maxpool2.sv
// ReLU + requantize + 2x2 stride-2 max pool over a raster stream with no backpressure.
module relu_maxpool2
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int SHIFT = DEF_SHIFT,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_done
);

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [OUT_W-1:0] hold_reg;
  logic [OUT_W-1:0] q;
  logic [OUT_W-1:0] h;
  logic [OUT_W-1:0] pool;
  logic [OUT_W-1:0] lb_rd;
  logic [AW-1:0]    lb_addr;
  logic             lb_we;
  logic             last_col;
  logic             last_row;

  assign q    = OUT_W'(relu_requant(MAX_W'($signed(in_data)), SHIFT, OUT_W));
  assign h    = OUT_W'(umax(MAX_W'(hold_reg), MAX_W'(q)));
  assign pool = OUT_W'(umax(MAX_W'(lb_rd), MAX_W'(h)));

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

  // Even rows write at odd columns, odd rows read there, so one address serves both ports.
  assign lb_addr = AW'(col >> 1);
  assign lb_we   = in_valid && col[0] && !row[0];

  pool_line_buffer #(
    .DEPTH (LB_D),
    .AW    (AW),
    .DW    (OUT_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_addr),
    .wr_data (h),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  // Raster position, horizontal hold, and the registered pooled output / frame strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      hold_reg   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        // An odd column always has an even partner, so unpaired trailing columns never reach here.
        if (!col[0]) begin
          hold_reg <= q;
        end
        if (col[0] && row[0]) begin
          out_valid <= 1'b1;
          out_data  <= pool;
        end
        if (last_col) begin
          col        <= '0;
          row        <= last_row ? '0 : row + RW'(1);
          frame_done <= last_row;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2.sv
// Scoreboard bench: three instances (4x4 shift 0, 4x4 shift 12, 5x5 shift 0).
module tb_relu_maxpool2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        iv  [3];
  logic [31:0] id  [3];
  logic        ov  [3];
  logic [15:0] od  [3];
  logic        fd  [3];

  relu_maxpool2 #(.IMG_W(4), .IMG_H(4), .SHIFT(0), .IN_W(32), .OUT_W(16)) dut_a (
    .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_data(od[0]), .frame_done(fd[0]));

  relu_maxpool2 #(.IMG_W(4), .IMG_H(4), .SHIFT(12), .IN_W(32), .OUT_W(16)) dut_b (
    .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_data(od[1]), .frame_done(fd[1]));

  relu_maxpool2 #(.IMG_W(5), .IMG_H(5), .SHIFT(0), .IN_W(32), .OUT_W(16)) dut_c (
    .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_data(od[2]), .frame_done(fd[2]));

  typedef struct {
    int          dut;
    logic [15:0] val;
    longint      cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t fd_q[$];

  longint      cyc = 0;
  logic        rs [3];
  logic [15:0] last_od [3];
  int          compared = 0;
  int          mismatched = 0;

  // Row-major 4x4 frame for the shift-12 instance; windows give 10, 0x7FFF, 0, 300.
  int bvals [16] = '{
    -5,         40960,   32'h7FFFFFFF, 100,
    8192,       4096,    12288,        0,
    -1,         -100000, 4095,         28672,
    32'h80000000, -4096, 8191,         1228800
  };

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) rs[k] <= rst[k];
  end

  function automatic int find_exp(input int k);
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].dut == k) return i;
    return -1;
  endfunction

  function automatic int find_fd(input int k);
    for (int i = 0; i < fd_q.size(); i++) if (fd_q[i].dut == k) return i;
    return -1;
  endfunction

  // Monitor: compares every DUT output against the scoreboard on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rs[k] === 1'b1) begin
        compared++;
        if (ov[k] !== 1'b0 || od[k] !== 16'h0 || fd[k] !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_state dut%0d: got valid=%b data=%h done=%b, want 0/0000/0",
                   k, ov[k], od[k], fd[k]);
        end
        last_od[k] = 16'h0;
      end else begin
        if (ov[k] === 1'b1) begin
          int idx;
          idx = find_exp(k);
          compared++;
          if (idx < 0) begin
            mismatched++;
            $display("FAIL unexpected_out dut%0d cyc=%0d: got data=%h, want no output", k, cyc, od[k]);
          end else begin
            if (od[k] !== exp_q[idx].val || cyc != exp_q[idx].cyc) begin
              mismatched++;
              $display("FAIL pooled_out dut%0d: got data=%h at cyc %0d, want %h at cyc %0d",
                       k, od[k], cyc, exp_q[idx].val, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
          end
        end else begin
          compared++;
          if (od[k] !== last_od[k]) begin
            mismatched++;
            $display("FAIL data_hold dut%0d cyc=%0d: got %h while idle, want held %h",
                     k, cyc, od[k], last_od[k]);
          end
        end
        if (fd[k] === 1'b1) begin
          int fidx;
          fidx = find_fd(k);
          compared++;
          if (fidx < 0) begin
            mismatched++;
            $display("FAIL unexpected_frame_done dut%0d cyc=%0d: got pulse, want none", k, cyc);
          end else begin
            if (cyc != fd_q[fidx].cyc) begin
              mismatched++;
              $display("FAIL frame_done_time dut%0d: got cyc %0d, want cyc %0d", k, cyc, fd_q[fidx].cyc);
            end
            fd_q.delete(fidx);
          end
        end
        last_od[k] = od[k];
      end
    end
  end

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      iv[k] = 1'b0;
    end
  endtask

  task automatic drive(input int k, input logic [31:0] d, input bit push,
                       input logic [15:0] e, input bit fdone);
    exp_t x;
    @(negedge clk);
    iv[k] = 1'b1;
    id[k] = d;
    x.dut = k;
    x.cyc = cyc + 1;
    if (push) begin
      x.val = e;
      exp_q.push_back(x);
    end
    if (fdone) begin
      x.val = 16'h0;
      fd_q.push_back(x);
    end
  endtask

  // mode 0: 1..N ramp, mode 1: N..1, mode 2: bvals table. Expected outputs are hand-computed.
  task automatic run_frame(input int k, input int w, input int h, input int mode,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input bit gaps);
    logic [15:0] ex [4];
    int n;
    int r;
    int c;
    int v;
    bit p;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    n = 0;
    for (int i = 0; i < w * h; i++) begin
      r = i / w;
      c = i % w;
      if (mode == 0) v = i + 1;
      else if (mode == 1) v = w * h - i;
      else v = bvals[i];
      p = (r % 2 == 1) && (c % 2 == 1);
      if (gaps) idle(k, $urandom_range(0, 3));
      drive(k, v, p, p ? ex[n] : 16'h0, i == w * h - 1);
      if (p) n++;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      iv[k]  = 1'b1;
      id[k]  = $urandom;
    end
    // Three reset cycles with in_valid toggling and junk data.
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        iv[k] = ~iv[k];
        id[k] = $urandom;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      iv[k]  = 1'b0;
    end

    // Basic pool, then a back-to-back reversed frame with no bubble.
    run_frame(0, 4, 4, 0, 16'd6, 16'd8, 16'd14, 16'd16, 1'b0);
    run_frame(0, 4, 4, 1, 16'd16, 16'd14, 16'd8, 16'd6, 1'b0);
    idle(0, 3);

    // Gapped input.
    run_frame(0, 4, 4, 0, 16'd6, 16'd8, 16'd14, 16'd16, 1'b1);
    idle(0, 2);

    // Mid-frame reset: partial frame must vanish without any output.
    for (int i = 0; i < 5; i++) drive(0, 100 + i, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    iv[0]  = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    run_frame(0, 4, 4, 0, 16'd6, 16'd8, 16'd14, 16'd16, 1'b0);
    idle(0, 3);

    // ReLU, shift and saturation.
    run_frame(1, 4, 4, 2, 16'd10, 16'h7FFF, 16'd0, 16'd300, 1'b0);
    idle(1, 3);

    // Odd dimensions: trailing column and row never pool.
    run_frame(2, 5, 5, 0, 16'd7, 16'd9, 16'd17, 16'd19, 1'b0);
    idle(2, 4);

    compared++;
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_outputs: got %0d pixels and %0d frame_done outstanding, want 0 and 0",
               exp_q.size(), fd_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
